retire_trace_buffer: RTL

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

---
 rtl/retire_pkg.sv | 12 +
 rtl/trace_fifo.sv | 59 +++++
 rtl/retire_trace_buffer.sv | 99 +++++++++
 3 files changed

// File: rtl/retire_pkg.sv
// Shared types and defaults for the retire trace buffer.
// Trace entries carry the retire sequence number, destination register and written value.
package retire_pkg;
    localparam int SEQ_W         = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [4:0]       rd;
        logic [31:0]      data;
    } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through FIFO of trace entries with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo
    import retire_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  trace_entry_t           i_entry,
    input  logic                   i_pop,
    output trace_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    trace_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/retire_trace_buffer.sv
// Captures retired register writes into a trace FIFO with sequence numbers,
// counts events lost to a full FIFO, and mirrors the register file in a shadow copy.
module retire_trace_buffer
    import retire_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic [31:0]            wb_data,
    output logic                   tr_valid,
    input  logic                   tr_ready,
    output logic [SEQ_W-1:0]       tr_seq,
    output logic [4:0]             tr_rd,
    output logic [31:0]            tr_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt,
    input  logic                   clr_overflow,
    input  logic [4:0]             shadow_addr,
    output logic [31:0]            shadow_data
);
    logic [SEQ_W-1:0]  r_seq;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [31:0]       r_shadow [32];

    logic              w_evt;
    logic              w_pop;
    logic              w_full;
    logic              w_drop;
    trace_entry_t      w_entry;
    trace_entry_t      w_head;
    logic [$clog2(DEPTH):0] w_count;

    // Writes to x0 are architectural no-ops, so they are not traced at all.
    assign w_evt   = wb_valid && (wb_rd != 5'd0);
    assign w_pop   = tr_valid && tr_ready;
    assign w_drop  = w_evt && w_full && !w_pop;
    assign w_entry = '{seq: r_seq, rd: wb_rd, data: wb_data};

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_evt),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign count       = w_count;
    assign tr_valid    = (w_count != '0);
    assign tr_seq      = w_head.seq;
    assign tr_rd       = w_head.rd;
    assign tr_data     = w_head.data;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;
    assign shadow_data = (shadow_addr == 5'd0) ? 32'd0 : r_shadow[shadow_addr];

    // Seq advances even on dropped events so the consumer can see the gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_evt) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
            if (clr_overflow) begin
                r_drop_cnt <= w_drop ? DROP_W'(1) : '0;
            end else if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_evt) begin
            r_shadow[wb_rd] <= wb_data;
        end
    end
endmodule
